// File: rtl/iter_div.sv
// iter_div: iterative radix-2 restoring divider with a valid/ready request
// side, a valid/ready result side and a synchronous flush. Signed operands
// are reduced to magnitudes on acceptance, and the signs are re-applied on
// the last iteration. Signed results truncate toward zero.
module iter_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_acc;   // partial remainder
    logic [WIDTH-1:0] quo_acc;   // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] div_mag;
    logic             q_neg;
    logic             r_neg;
    logic             dz_lat;

    logic             accept;
    logic             take;
    logic             last_step;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH:0]   rem_shift;
    logic             step_ok;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] res_quo;
    logic [WIDTH-1:0] res_rem;

    // Handshake and status decode. in_ready is held low during reset and
    // whenever flush is requested, so flush always wins over acceptance.
    assign in_ready  = resetn && (state == ST_IDLE) && !flush;
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign take      = out_valid && out_ready;
    assign last_step = (state == ST_CALC) && (cnt == LAST_STEP);

    // Operand magnitudes; in unsigned mode the operands pass through untouched.
    // The most-negative value maps onto itself, which is the correct unsigned
    // magnitude 2**(WIDTH-1).
    assign dividend_mag = (in_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    assign divisor_mag  = (in_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits. The partial remainder is
    // always below the divisor, so a successful difference fits in WIDTH bits.
    assign rem_shift = {rem_acc, quo_acc[WIDTH-1]};
    assign step_ok   = (rem_shift >= {1'b0, div_mag});
    assign step_rem  = step_ok ? (rem_shift[WIDTH-1:0] - div_mag) : rem_shift[WIDTH-1:0];
    assign step_quo  = {quo_acc[WIDTH-2:0], step_ok};

    // Sign correction on the final step. A zero divisor leaves the magnitude of
    // the dividend in the remainder, so re-applying the dividend sign restores
    // the original dividend; only the quotient needs forcing to all ones.
    assign res_quo = dz_lat ? {WIDTH{1'b1}} : (q_neg ? -step_quo : step_quo);
    assign res_rem = r_neg ? -step_rem : step_rem;

    // Next-state logic; flush forces IDLE from any state.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)    state_nxt = ST_CALC;
            ST_CALC: if (last_step) state_nxt = ST_DONE;
            ST_DONE: if (take)      state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
        if (flush) begin
            state_nxt = ST_IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: non-blocking assignments for all clocked state so every register samples pre-edge values.
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture on acceptance, then one restoring step per CALC cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt     <= '0;
            rem_acc <= '0;
            quo_acc <= '0;
            div_mag <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            dz_lat  <= 1'b0;
        end else if (accept) begin
            cnt     <= '0;
            rem_acc <= '0;
            quo_acc <= dividend_mag;
            div_mag <= divisor_mag;
            q_neg   <= in_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg   <= in_signed && dividend[WIDTH-1];
            dz_lat  <= (divisor == '0);
        end else if ((state == ST_CALC) && !flush) begin
            rem_acc <= step_rem;
            quo_acc <= step_quo;
            if (!last_step) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Result registers: loaded on the final step, cleared whenever the result
    // is taken or cancelled so they read zero outside DONE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (flush || take) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (last_step) begin
            quotient    <= res_quo;
            remainder   <= res_rem;
            div_by_zero <= dz_lat;
        end
    end

endmodule

// File: tb/tb_iter_div.sv
// tb_iter_div: directed vectors with hand-computed results. Expected results
// go into a scoreboard queue when a request is issued; a monitor pops and
// compares each time a result is transferred.
module tb_iter_div;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic        in_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
    logic        busy;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } exp_t;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } vec_t;

    exp_t sb[$];
    vec_t vt[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    iter_div #(.WIDTH(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_signed  (in_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every transferred result must match the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (resetn && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result: got q=0x%0h r=0x%0h, expected no out_valid (t=%0t)",
                         quotient, remainder, $time);
            end else begin
                e = sb.pop_front();
                check("quotient", {32'h0, quotient}, {32'h0, e.q});
                check("remainder", {32'h0, remainder}, {32'h0, e.r});
                check("div_by_zero", {63'h0, div_by_zero}, {63'h0, e.dz});
            end
        end
    end

    // Waits for in_ready, presents one request for exactly one accepting
    // edge, then scrambles the inputs. k is the acceptance cycle.
    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b, output int k);
        int waited = 0;
        @(posedge clk); #1;
        while (!in_ready && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        check("in_ready_before_issue", {63'h0, in_ready}, 64'h1);
        in_valid  = 1'b1;
        in_signed = sgn;
        dividend  = a;
        divisor   = b;
        k         = cyc;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_signed = ~sgn;
        dividend  = 32'hDEAD_BEEF;
        divisor   = 32'h0;
    endtask

    task automatic push_exp(input logic [31:0] q, input logic [31:0] r, input logic dz);
        exp_t e;
        e.q  = q;
        e.r  = r;
        e.dz = dz;
        sb.push_back(e);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_scoreboard", 64'(sb.size()), 64'h0);
    endtask

    initial begin
        int k;
        int lat;
        int n;

        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        flush     = 1'b0;
        out_ready = 1'b1;

        vt.push_back('{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0});
        vt.push_back('{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0});
        vt.push_back('{1'b0, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0005, 1'b1});
        vt.push_back('{1'b1, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1});
        vt.push_back('{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0});
        vt.push_back('{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0});
        vt.push_back('{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'h0000_000E, 32'hFFFF_FFFE, 1'b0});
        vt.push_back('{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0});
        vt.push_back('{1'b0, 32'h0000_0000, 32'h0000_0009, 32'h0000_0000, 32'h0000_0000, 1'b0});
        vt.push_back('{1'b1, 32'h8000_0000, 32'h0000_0002, 32'hC000_0000, 32'h0000_0000, 1'b0});
        vt.push_back('{1'b1, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1});

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_out_valid", {63'h0, out_valid}, 64'h0);
        check("rst_in_ready", {63'h0, in_ready}, 64'h0);
        check("rst_busy", {63'h0, busy}, 64'h0);
        check("rst_quotient", {32'h0, quotient}, 64'h0);
        check("rst_remainder", {32'h0, remainder}, 64'h0);
        check("rst_div_by_zero", {63'h0, div_by_zero}, 64'h0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", {63'h0, in_ready}, 64'h1);

        // Unsigned 100/7 with latency measurement; outputs read zero in CALC.
        push_exp(32'd14, 32'd2, 1'b0);
        issue(1'b0, 32'd100, 32'd7, k);
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 5) begin
                check("calc_quotient_zero", {32'h0, quotient}, 64'h0);
                check("calc_remainder_zero", {32'h0, remainder}, 64'h0);
                check("calc_busy", {63'h0, busy}, 64'h1);
                check("calc_out_valid", {63'h0, out_valid}, 64'h0);
            end
            if (out_valid) begin
                lat = cyc - k;
                break;
            end
        end
        check("latency", 64'(lat), 64'd33);
        wait_drain();

        // Directed vector table.
        foreach (vt[i]) begin
            push_exp(vt[i].q, vt[i].r, vt[i].dz);
            issue(vt[i].sgn, vt[i].a, vt[i].b, k);
            wait_drain();
        end

        // Back-pressure: hold out_ready low for five DONE cycles.
        @(posedge clk); #1;
        out_ready = 1'b0;
        push_exp(32'd333, 32'd1, 1'b0);
        issue(1'b0, 32'd1000, 32'd3, k);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check("hold_out_valid", {63'h0, out_valid}, 64'h1);
            check("hold_in_ready", {63'h0, in_ready}, 64'h0);
            check("hold_quotient", {32'h0, quotient}, 64'd333);
            check("hold_remainder", {32'h0, remainder}, 64'd1);
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("idle_after_take_busy", {63'h0, busy}, 64'h0);
        check("idle_after_take_valid", {63'h0, out_valid}, 64'h0);
        wait_drain();

        // Flush in cycle k+10 cancels the request; IDLE and ready in k+11.
        issue(1'b0, 32'd1000, 32'd7, k);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_cycle", 64'(cyc - k), 64'd11);
        check("flush_in_ready", {63'h0, in_ready}, 64'h1);
        check("flush_busy", {63'h0, busy}, 64'h0);
        repeat (40) @(negedge clk);
        push_exp(32'h0FFF_FFFF, 32'h0000_000F, 1'b0);
        issue(1'b0, 32'hFFFF_FFFF, 32'h0000_0010, k);
        wait_drain();

        // Flush in DONE together with out_ready: the transfer still completes.
        push_exp(32'd50, 32'd0, 1'b0);
        issue(1'b0, 32'd100, 32'd2, k);
        repeat (32) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_done_busy", {63'h0, busy}, 64'h0);
        wait_drain();

        // Reset pulse mid-CALC discards the operation.
        issue(1'b0, 32'd123, 32'd4, k);
        repeat (10) @(posedge clk);
        #1;
        resetn = 1'b0;
        #2;
        check("midrst_out_valid", {63'h0, out_valid}, 64'h0);
        check("midrst_busy", {63'h0, busy}, 64'h0);
        check("midrst_in_ready", {63'h0, in_ready}, 64'h0);
        check("midrst_quotient", {32'h0, quotient}, 64'h0);
        check("midrst_remainder", {32'h0, remainder}, 64'h0);
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (45) @(negedge clk);
        check("post_reset_busy", {63'h0, busy}, 64'h0);
        check("post_reset_in_ready", {63'h0, in_ready}, 64'h1);
        check("scoreboard_empty", 64'(sb.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/iter_div.md
ITER_DIV -- requirements
Module: iter_div

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; legal range 2..64.
REQ-002 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port resetn  input  1  asynchronous, active-low reset.
REQ-004 Port in_valid  input  1  request present.
REQ-005 Port in_ready  output  1  block can accept a request this cycle.
REQ-006 Port in_signed  input  1  1 = two's-complement divide, 0 = unsigned.
REQ-007 Port dividend  input  WIDTH  numerator.
REQ-008 Port divisor  input  WIDTH  denominator.
REQ-009 Port flush  input  1  cancel any request that is in flight or completed but not yet taken.
REQ-010 Port out_valid  output  1  result present.
REQ-011 Port out_ready  input  1  consumer takes the result this cycle.
REQ-012 Port quotient  output  WIDTH  quotient result.
REQ-013 Port remainder  output  WIDTH  remainder result.
REQ-014 Port div_by_zero  output  1  the divisor of the current result was 0.
REQ-015 Port busy  output  1  state is not IDLE.

Function
REQ-016 The block SHALL implement a three-state FSM with states IDLE, CALC and DONE.
REQ-017 The block SHALL drive in_ready=1 only in IDLE with flush=0; a request is accepted when in_valid && in_ready.
REQ-018 On acceptance the block SHALL latch in_signed, dividend and divisor; input changes after acceptance SHALL have no effect.
REQ-019 On acceptance the block SHALL convert operands to magnitudes (when signed) and record the quotient sign (sign(dividend) XOR sign(divisor)) and the remainder sign (sign(dividend)).
REQ-020 CALC SHALL perform one radix-2 restoring step per cycle for exactly WIDTH cycles, using a step counter of clog2(WIDTH+1) bits; the counter SHALL NOT wrap.
REQ-021 On the final CALC edge the block SHALL apply the sign correction, register the results and enter DONE.
REQ-022 Latency: if the request is accepted in cycle k, out_valid SHALL first be 1 in cycle k+WIDTH+1.
REQ-023 In DONE, out_valid SHALL be 1 and quotient, remainder and div_by_zero SHALL be held stable until out_valid && out_ready.
REQ-024 On out_valid && out_ready the block SHALL return to IDLE; the next acceptance is therefore possible no earlier than the following cycle (one-cycle bubble).
REQ-025 Divide by zero SHALL take the full latency and produce quotient={WIDTH{1}}, remainder=dividend (original, unmodified value) and div_by_zero=1, in both modes.
REQ-026 Signed overflow (most-negative value / -1) SHALL produce quotient = most-negative value, remainder = 0 and div_by_zero = 0.
REQ-027 Signed results SHALL truncate toward zero, and the remainder SHALL carry the sign of the dividend.
REQ-028 flush=1 in any state SHALL force IDLE at the next edge, with no out_valid produced for the cancelled request.
REQ-029 flush has priority over acceptance: when flush=1 in IDLE, in_valid SHALL be ignored that cycle.
REQ-030 flush in DONE with out_ready=1 in the same cycle: the transfer SHALL still complete that cycle, because out_valid=1 is visible; the FSM then goes to IDLE.
REQ-031 out_valid SHALL never be 1 outside DONE.
REQ-032 quotient and remainder SHALL be 0 in IDLE and CALC.

Reset
REQ-033 resetn=0 SHALL asynchronously force IDLE, out_valid=0, in_ready=0 while asserted, busy=0, quotient=0, remainder=0, div_by_zero=0 and counter=0.
REQ-034 Reset asserted mid-CALC or mid-DONE SHALL discard the operation; no out_valid is produced after release.
REQ-035 After reset release, in_ready SHALL be 1 in the first cycle with flush=0.

Verification (WIDTH=32)
REQ-036 Unsigned 100/7 accepted in cycle k -> out_valid first in cycle k+33, quotient=14, remainder=2, div_by_zero=0.
REQ-037 Signed -7/2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; signed 7/-2 -> quotient=0xFFFFFFFD, remainder=1.
REQ-038 Unsigned 5/0 and signed -5/0 -> quotient=0xFFFFFFFF, remainder=5 and 0xFFFFFFFB respectively, div_by_zero=1; signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
REQ-039 Flush in cycle k+10 of a request -> no out_valid; in_ready=1 in cycle k+11; a new 0xFFFFFFFF/0x10 (unsigned) request -> quotient=0x0FFFFFFF, remainder=0xF.
REQ-040 Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0; then out_ready=1 -> IDLE next cycle; resetn pulse mid-CALC -> all outputs 0 and no out_valid afterwards.
